// File: rtl/sparrow_pkg.sv
// Shared types and defaults for the sparrow core.
// Owner tags identify which requester issued an outstanding memory transaction.
package sparrow_pkg;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  localparam int unsigned SPARROW_MEM_MAX_OUTSTANDING = 32'd2;
  localparam int unsigned SPARROW_MEM_MAX_DATA_STREAK = 32'd4;

endpackage

// File: rtl/sparrow_owner_fifo.sv
// Small synchronous FIFO with occupancy count; push is dropped when full and
// pop is ignored when empty, so callers may drive them unconditionally.
module sparrow_owner_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH + 1)-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return ptr + PTR_W'(1);
    end
  endfunction

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == CNT_W'(0));
  assign count     = count_r;
  assign head      = store_r[rd_ptr_r];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Pointer, occupancy and storage update.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        store_r[i] <= '0;
      end
    end else begin
      if (push_ok_s) begin
        store_r[wr_ptr_r] <= push_data;
        wr_ptr_r          <= ptr_inc(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      count_r <= count_r + CNT_W'(push_ok_s) - CNT_W'(pop_ok_s);
    end
  end

endmodule

// File: rtl/sparrow_mem_arbiter.sv
// Shares one memory port between fetch and LSU: data-first arbitration with a
// bounded fetch starvation window, request locking under stall, in-order response routing.
module sparrow_mem_arbiter
  import sparrow_pkg::*;
#(
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned DATA_W          = 32,
  parameter int unsigned MAX_OUTSTANDING = SPARROW_MEM_MAX_OUTSTANDING,
  parameter int unsigned MAX_DATA_STREAK = SPARROW_MEM_MAX_DATA_STREAK
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                instr_req_i,
  input  logic [ADDR_W-1:0]   instr_addr_i,
  output logic                instr_gnt_o,
  output logic                instr_rvalid_o,
  output logic [DATA_W-1:0]   instr_rdata_o,
  input  logic                data_req_i,
  input  logic                data_we_i,
  input  logic [DATA_W/8-1:0] data_be_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  output logic                data_gnt_o,
  output logic                data_rvalid_o,
  output logic [DATA_W-1:0]   data_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                proto_err_o
);

  localparam int unsigned STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam int unsigned CNT_W    = $clog2(MAX_OUTSTANDING + 1);

  logic                lock_r;
  owner_e              lock_owner_r;
  logic [STREAK_W-1:0] streak_r;
  logic [STREAK_W-1:0] streak_nxt_s;
  logic                proto_err_r;

  owner_e              sel_s;
  owner_e              head_owner_s;
  logic                locked_req_s;
  logic                streak_max_s;
  logic                full_s;
  logic                xfer_s;
  logic                pop_s;
  logic [0:0]          push_owner_s;
  logic [0:0]          fifo_head_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic [CNT_W-1:0]    fifo_count_s;

  sparrow_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (1)
  ) u_owner_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (xfer_s),
    .push_data (push_owner_s),
    .pop       (pop_s),
    .head      (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  assign full_s       = fifo_full_s & (fifo_count_s == CNT_W'(MAX_OUTSTANDING));
  assign head_owner_s = owner_e'(fifo_head_s);
  assign push_owner_s = sel_s;
  assign streak_max_s = (streak_r == STREAK_W'(MAX_DATA_STREAK));
  assign locked_req_s = (lock_owner_r == OWNER_INSTR) ? instr_req_i : data_req_i;

  // Requester selection; a held lock only survives while its owner keeps requesting.
  always_comb begin
    sel_s = OWNER_DATA;
    if (lock_r && locked_req_s) begin
      sel_s = lock_owner_r;
    end else if (data_req_i && !(streak_max_s && instr_req_i)) begin
      sel_s = OWNER_DATA;
    end else if (instr_req_i) begin
      sel_s = OWNER_INSTR;
    end else begin
      sel_s = OWNER_DATA;
    end
  end

  assign mem_req_o   = reset_n & (instr_req_i | data_req_i) & ~full_s;
  assign xfer_s      = mem_req_o & mem_gnt_i;
  assign instr_gnt_o = xfer_s & (sel_s == OWNER_INSTR);
  assign data_gnt_o  = xfer_s & (sel_s == OWNER_DATA);

  // Request field mux; idle cycles drive zeros so the bus never floats.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (mem_req_o) begin
      case (sel_s)
        OWNER_DATA: begin
          mem_we_o    = data_we_i;
          mem_be_o    = data_be_i;
          mem_addr_o  = data_addr_i;
          mem_wdata_o = data_wdata_i;
        end
        OWNER_INSTR: begin
          mem_be_o   = '1;
          mem_addr_o = instr_addr_i;
        end
        default: begin
          mem_we_o = 1'b0;
        end
      endcase
    end else begin
      mem_we_o = 1'b0;
    end
  end

  assign pop_s          = mem_rvalid_i & ~fifo_empty_s;
  assign instr_rvalid_o = reset_n & pop_s & (head_owner_s == OWNER_INSTR);
  assign data_rvalid_o  = reset_n & pop_s & (head_owner_s == OWNER_DATA);
  assign proto_err_o    = proto_err_r;

  // Response data fans out to both requesters; held at zero while in reset.
  always_comb begin
    instr_rdata_o = '0;
    data_rdata_o  = '0;
    if (reset_n) begin
      instr_rdata_o = mem_rdata_i;
      data_rdata_o  = mem_rdata_i;
    end else begin
      instr_rdata_o = '0;
      data_rdata_o  = '0;
    end
  end

  // Streak counts data wins only while fetch is actually waiting.
  always_comb begin
    streak_nxt_s = streak_r;
    if (!instr_req_i || instr_gnt_o) begin
      streak_nxt_s = '0;
    end else if (data_gnt_o && !streak_max_s) begin
      streak_nxt_s = streak_r + STREAK_W'(1);
    end else begin
      streak_nxt_s = streak_r;
    end
  end

  // Lock, streak and sticky protocol-error state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_r       <= 1'b0;
      lock_owner_r <= OWNER_INSTR;
      streak_r     <= '0;
      proto_err_r  <= 1'b0;
    end else begin
      lock_r       <= mem_req_o & ~mem_gnt_i;
      lock_owner_r <= sel_s;
      streak_r     <= streak_nxt_s;
      if (mem_rvalid_i && fifo_empty_s) begin
        proto_err_r <= 1'b1;
      end else begin
        proto_err_r <= proto_err_r;
      end
    end
  end

endmodule

// File: tb/tb_sparrow_mem_arbiter.sv
// Directed bench: stimulus queues expected grants/responses, a negedge monitor
// pops and compares whenever the arbiter presents a grant or a routed response.
module tb_sparrow_mem_arbiter;

  localparam logic O_I = 1'b0;
  localparam logic O_D = 1'b1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o, instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i, data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i, data_wdata_i;
  logic        data_gnt_o, data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        proto_err_o;

  typedef struct {
    logic        owner;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } gnt_t;

  typedef struct {
    logic        owner;
    logic [31:0] rdata;
  } rsp_t;

  gnt_t gnt_q[$];
  rsp_t rsp_q[$];
  gnt_t mg;
  rsp_t mr;
  int   total = 0;
  int   bad   = 0;

  sparrow_mem_arbiter dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .data_req_i     (data_req_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_addr_i    (data_addr_i),
    .data_wdata_i   (data_wdata_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .proto_err_o    (proto_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic exp_gnt(input logic o, input logic [31:0] a, input logic we, input logic [31:0] wd);
    gnt_t g;
    g.owner = o; g.addr = a; g.we = we; g.wdata = wd;
    gnt_q.push_back(g);
  endtask

  task automatic exp_rsp(input logic o, input logic [31:0] d);
    rsp_t r;
    r.owner = o; r.rdata = d;
    rsp_q.push_back(r);
  endtask

  task automatic idle();
    instr_req_i = 1'b0; data_req_i = 1'b0; data_we_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Monitor: any grant or routed response must match the head of its queue.
  always @(negedge clk) begin
    if (instr_gnt_o || data_gnt_o) begin
      if (gnt_q.size() == 0) begin
        check("unexpected_gnt", {62'd0, instr_gnt_o, data_gnt_o}, 64'd0);
      end else begin
        mg = gnt_q.pop_front();
        check("gnt_owner", {62'd0, instr_gnt_o, data_gnt_o}, mg.owner ? 64'd1 : 64'd2);
        check("gnt_addr", {32'd0, mem_addr_o}, {32'd0, mg.addr});
        check("gnt_we", {63'd0, mem_we_o}, {63'd0, mg.we});
        if (mg.we) check("gnt_wdata", {32'd0, mem_wdata_o}, {32'd0, mg.wdata});
      end
    end
    if (instr_rvalid_o || data_rvalid_o) begin
      if (rsp_q.size() == 0) begin
        check("unexpected_rsp", {62'd0, instr_rvalid_o, data_rvalid_o}, 64'd0);
      end else begin
        mr = rsp_q.pop_front();
        check("rsp_owner", {62'd0, instr_rvalid_o, data_rvalid_o}, mr.owner ? 64'd1 : 64'd2);
        check("rsp_rdata", {32'd0, mr.owner ? data_rdata_o : instr_rdata_o}, {32'd0, mr.rdata});
      end
    end
  end

  initial begin
    logic [6:0]  seq;
    logic        prev_own;
    logic        own;
    int          dcnt;

    reset_n = 1'b0;
    instr_req_i = 1'b1; instr_addr_i = 32'h0000_0100;
    data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF;
    data_addr_i = 32'h0000_0000; data_wdata_i = 32'h0000_0000;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0055;
    repeat (2) @(posedge clk);
    settle();
    check("rst_mem_req", {63'd0, mem_req_o}, 64'd0);
    check("rst_gnts", {62'd0, instr_gnt_o, data_gnt_o}, 64'd0);
    check("rst_rvalids", {62'd0, instr_rvalid_o, data_rvalid_o}, 64'd0);
    check("rst_proto_err", {63'd0, proto_err_o}, 64'd0);
    next();
    idle();
    reset_n = 1'b1;
    next();

    // Lone fetch.
    instr_req_i = 1'b1; instr_addr_i = 32'h0000_0100; mem_gnt_i = 1'b1;
    exp_gnt(O_I, 32'h0000_0100, 1'b0, 32'h0);
    settle(); next();
    instr_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    exp_rsp(O_I, 32'hDEAD_BEEF);
    settle(); next(); idle();

    // Simultaneous requests: data first, then fetch; responses in the same order.
    instr_req_i = 1'b1; instr_addr_i = 32'h0000_0200;
    data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'h0000_0080; data_wdata_i = 32'hCAFE_0001;
    mem_gnt_i = 1'b1;
    exp_gnt(O_D, 32'h0000_0080, 1'b1, 32'hCAFE_0001);
    settle(); next();
    data_req_i = 1'b0; data_we_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0000;
    exp_rsp(O_D, 32'h0000_0000);
    exp_gnt(O_I, 32'h0000_0200, 1'b0, 32'h0);
    settle(); next();
    instr_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rdata_i = 32'h1234_5678;
    exp_rsp(O_I, 32'h1234_5678);
    settle(); next(); idle();

    // Lock under stall: fetch stays on the bus even after data starts asking.
    instr_req_i = 1'b1; instr_addr_i = 32'h0000_0200; mem_gnt_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        data_req_i = 1'b1; data_addr_i = 32'h0000_0084;
      end
      settle();
      check("lock_req", {63'd0, mem_req_o}, 64'd1);
      check("lock_addr", {32'd0, mem_addr_o}, 64'h200);
      next();
    end
    mem_gnt_i = 1'b1;
    exp_gnt(O_I, 32'h0000_0200, 1'b0, 32'h0);
    settle(); next();
    instr_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_0000;
    exp_rsp(O_I, 32'h1111_0000);
    exp_gnt(O_D, 32'h0000_0084, 1'b0, 32'h0);
    settle(); next();
    data_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rdata_i = 32'h2222_0000;
    exp_rsp(O_D, 32'h2222_0000);
    settle(); next(); idle();

    // Starvation bound: four data grants, one fetch grant, then data resumes.
    seq = 7'b110_1111;
    dcnt = 0;
    prev_own = O_D;
    instr_req_i = 1'b1; instr_addr_i = 32'h0000_0300;
    data_req_i = 1'b1; mem_gnt_i = 1'b1;
    for (int k = 0; k < 7; k++) begin
      own = seq[k];
      data_addr_i = 32'h0000_0400 + 32'(dcnt * 4);
      exp_gnt(own, own ? data_addr_i : 32'h0000_0300, 1'b0, 32'h0);
      if (k > 0) begin
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA000_0000 + 32'(k);
        exp_rsp(prev_own, mem_rdata_i);
      end
      settle(); next();
      if (own) dcnt++;
      if (!own) instr_req_i = 1'b0;
      prev_own = own;
    end
    data_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA000_0007;
    exp_rsp(prev_own, 32'hA000_0007);
    settle(); next(); idle();

    // Full backpressure: two outstanding block the port until a response pops.
    data_req_i = 1'b1; data_addr_i = 32'h0000_0500; mem_gnt_i = 1'b1;
    exp_gnt(O_D, 32'h0000_0500, 1'b0, 32'h0);
    settle(); next();
    data_addr_i = 32'h0000_0504;
    exp_gnt(O_D, 32'h0000_0504, 1'b0, 32'h0);
    settle(); next();
    instr_req_i = 1'b1; instr_addr_i = 32'h0000_0600; data_addr_i = 32'h0000_0508;
    settle();
    check("full_req_low", {63'd0, mem_req_o}, 64'd0);
    next();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h3333_0000;
    exp_rsp(O_D, 32'h3333_0000);
    settle();
    check("full_same_cycle_pop", {63'd0, mem_req_o}, 64'd0);
    next();
    mem_rvalid_i = 1'b0;
    exp_gnt(O_D, 32'h0000_0508, 1'b0, 32'h0);
    settle();
    check("full_relieved", {63'd0, mem_req_o}, 64'd1);
    next();
    data_req_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h4444_0000;
    exp_rsp(O_D, 32'h4444_0000);
    settle();
    check("full_again", {63'd0, mem_req_o}, 64'd0);
    next();
    mem_rdata_i = 32'h4545_0000;
    exp_rsp(O_D, 32'h4545_0000);
    exp_gnt(O_I, 32'h0000_0600, 1'b0, 32'h0);
    settle(); next();
    instr_req_i = 1'b0; mem_gnt_i = 1'b0; mem_rdata_i = 32'h5555_0000;
    exp_rsp(O_I, 32'h5555_0000);
    settle(); next(); idle();

    // Protocol error: response with nothing outstanding.
    settle();
    check("perr_idle", {63'd0, proto_err_o}, 64'd0);
    next();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0066;
    settle();
    check("perr_not_yet", {63'd0, proto_err_o}, 64'd0);
    next();
    mem_rvalid_i = 1'b0;
    settle();
    check("perr_set", {63'd0, proto_err_o}, 64'd1);
    next();
    settle();
    check("perr_sticky", {63'd0, proto_err_o}, 64'd1);
    next();

    // Reset mid-traffic discards the outstanding owner.
    data_req_i = 1'b1; data_addr_i = 32'h0000_0700; mem_gnt_i = 1'b1;
    exp_gnt(O_D, 32'h0000_0700, 1'b0, 32'h0);
    settle(); next();
    reset_n = 1'b0;
    instr_req_i = 1'b1; instr_addr_i = 32'h0000_0800; data_addr_i = 32'h0000_0704;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0077;
    settle();
    check("mid_rst_mem_req", {63'd0, mem_req_o}, 64'd0);
    check("mid_rst_addr", {32'd0, mem_addr_o}, 64'd0);
    check("mid_rst_gnts", {62'd0, instr_gnt_o, data_gnt_o}, 64'd0);
    check("mid_rst_rvalids", {62'd0, instr_rvalid_o, data_rvalid_o}, 64'd0);
    check("mid_rst_rdata", {32'd0, instr_rdata_o}, 64'd0);
    check("mid_rst_perr", {63'd0, proto_err_o}, 64'd0);
    next();
    reset_n = 1'b1;
    idle();
    settle();
    check("post_rst_perr_clear", {63'd0, proto_err_o}, 64'd0);
    next();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0088;
    settle();
    check("post_rst_no_route", {62'd0, instr_rvalid_o, data_rvalid_o}, 64'd0);
    next();
    mem_rvalid_i = 1'b0;
    settle();
    check("post_rst_perr_set", {63'd0, proto_err_o}, 64'd1);
    next();

    check("gnt_queue_drained", 64'(gnt_q.size()), 64'd0);
    check("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
